// File: rtl/cmp_minmax_ctrl.sv
// ============================================================================
//  Module      : cmp_minmax_ctrl
//  Description : Frame min/max/count sequencer. Streams signed samples through
//                one shared external signed comparator, comparing each sample
//                against the running maximum and then against the running
//                minimum, and reports max/min/count at the end of the frame.
//                Optional feature macro: MINMAX_IDX_EN (adds zero-based
//                max/min index outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_minmax_ctrl #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic [W-1:0]  cmp_a,
    output logic [W-1:0]  cmp_b,
    input  logic          cmp_gt,
    input  logic          cmp_lt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_max,
    output logic [W-1:0]  out_min,
    output logic [CW-1:0] out_cnt,
`ifdef MINMAX_IDX_EN
    output logic [CW-1:0] out_max_idx,
    output logic [CW-1:0] out_min_idx,
`endif
    output logic          busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FIRST  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CMPMAX = 3'd3;
    localparam logic [2:0] S_CMPMIN = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_armed;      // low for the first edge after reset release
    logic [W-1:0]  r_max;
    logic [W-1:0]  r_min;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_s;          // sample held across the two compare cycles
    logic          r_l;          // its last-sample flag
    logic          w_in_xfer;
    logic          w_out_xfer;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    assign out_max = r_max;
    assign out_min = r_min;
    assign out_cnt = r_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Arm START only from the second edge after reset release, so a START
    // coincident with reset deassertion is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start && r_armed) w_next_state = S_FIRST;
            S_FIRST:  if (w_in_xfer) w_next_state = in_last ? S_DONE : S_WAIT;
            S_WAIT:   if (w_in_xfer) w_next_state = S_CMPMAX;
            S_CMPMAX: w_next_state = S_CMPMIN;
            S_CMPMIN: w_next_state = r_l ? S_DONE : S_WAIT;
            S_DONE:   if (w_out_xfer) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode: handshakes, busy flag and comparator operand steering
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (r_state != S_IDLE);
        cmp_a     = '0;
        cmp_b     = '0;
        case (r_state)
            S_FIRST,
            S_WAIT:   in_ready = 1'b1;
            S_CMPMAX: begin
                cmp_a = r_s;
                cmp_b = r_max;
            end
            S_CMPMIN: begin
                cmp_a = r_s;
                cmp_b = r_min;
            end
            S_DONE:   out_valid = 1'b1;
            default:  ;
        endcase
    end

    // Frame datapath: seed on the first sample, then strict-compare updates
    // so ties keep the earliest max/min
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_min <= '0;
            r_cnt <= '0;
            r_s   <= '0;
            r_l   <= 1'b0;
        end else begin
            case (r_state)
                S_FIRST: begin
                    if (w_in_xfer) begin
                        r_max <= in_data;
                        r_min <= in_data;
                        r_cnt <= c_cnt_one;
                    end
                end
                S_WAIT: begin
                    if (w_in_xfer) begin
                        r_s <= in_data;
                        r_l <= in_last;
                    end
                end
                S_CMPMAX: begin
                    if (cmp_gt) r_max <= r_s;
                end
                S_CMPMIN: begin
                    if (cmp_lt) r_min <= r_s;
                    if (r_cnt != c_cnt_max) r_cnt <= r_cnt + c_cnt_one;
                end
                default: ;
            endcase
        end
    end

`ifdef MINMAX_IDX_EN
    logic [CW-1:0] r_max_idx;
    logic [CW-1:0] r_min_idx;

    assign out_max_idx = r_max_idx;
    assign out_min_idx = r_min_idx;

    // Index tracking: the count still holds the pre-increment value during
    // both compare cycles, which is the zero-based index of the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_idx <= '0;
            r_min_idx <= '0;
        end else begin
            case (r_state)
                S_FIRST: begin
                    if (w_in_xfer) begin
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                    end
                end
                S_CMPMAX: if (cmp_gt) r_max_idx <= r_cnt;
                S_CMPMIN: if (cmp_lt) r_min_idx <= r_cnt;
                default: ;
            endcase
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmp_minmax_ctrl.sv
// ============================================================================
//  Module      : tb_cmp_minmax_ctrl
//  Description : Directed self-checking bench for cmp_minmax_ctrl, with a
//                behavioural signed comparator beside each instance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_minmax_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: W=8, CW=8
    logic       start, in_valid, in_last, in_ready, out_valid, out_ready, busy;
    logic [7:0] in_data, cmp_a, cmp_b, out_max, out_min, out_cnt;
    logic       cmp_gt, cmp_lt;
`ifdef MINMAX_IDX_EN
    logic [7:0] out_max_idx, out_min_idx;
`endif

    // Instance B: W=8, CW=2
    logic       start2, in_valid2, in_last2, in_ready2, out_valid2, out_ready2, busy2;
    logic [7:0] in_data2, cmp_a2, cmp_b2, out_max2, out_min2;
    logic [1:0] out_cnt2;
    logic       cmp_gt2, cmp_lt2;
`ifdef MINMAX_IDX_EN
    logic [1:0] out_max_idx2, out_min_idx2;
`endif

    assign cmp_gt  = $signed(cmp_a)  > $signed(cmp_b);
    assign cmp_lt  = $signed(cmp_a)  < $signed(cmp_b);
    assign cmp_gt2 = $signed(cmp_a2) > $signed(cmp_b2);
    assign cmp_lt2 = $signed(cmp_a2) < $signed(cmp_b2);

    cmp_minmax_ctrl #(.W(8), .CW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_min(out_min), .out_cnt(out_cnt),
`ifdef MINMAX_IDX_EN
        .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
`endif
        .busy(busy)
    );

    cmp_minmax_ctrl #(.W(8), .CW(2)) u_dut_cw2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2), .in_ready(in_ready2),
        .cmp_a(cmp_a2), .cmp_b(cmp_b2), .cmp_gt(cmp_gt2), .cmp_lt(cmp_lt2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_max(out_max2), .out_min(out_min2), .out_cnt(out_cnt2),
`ifdef MINMAX_IDX_EN
        .out_max_idx(out_max_idx2), .out_min_idx(out_min_idx2),
`endif
        .busy(busy2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one sample on instance sel (0=A, 1=B) and hold it until accepted
    task automatic push(input bit sel, input logic [7:0] d, input logic last);
        int  n;
        logic rdy;
        n = 0;
        if (sel) begin in_valid2 = 1'b1; in_data2 = d; in_last2 = last; end
        else     begin in_valid  = 1'b1; in_data  = d; in_last  = last; end
        rdy = sel ? in_ready2 : in_ready;
        while (!rdy && n < 20) begin
            tick();
            n++;
            rdy = sel ? in_ready2 : in_ready;
        end
        chk("push_ready", 32'(rdy), 32'd1);
        tick();
        if (sel) begin in_valid2 = 1'b0; in_last2 = 1'b0; end
        else     begin in_valid  = 1'b0; in_last  = 1'b0; end
    endtask

    task automatic wait_valid(input bit sel);
        int  n;
        logic ov;
        n  = 0;
        ov = sel ? out_valid2 : out_valid;
        while (!ov && n < 50) begin
            tick();
            n++;
            ov = sel ? out_valid2 : out_valid;
        end
        chk("out_valid_wait", 32'(ov), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 0; in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
        start2 = 0; in_valid2 = 0; in_data2 = '0; in_last2 = 0; out_ready2 = 0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_cmp_a",     32'(cmp_a),     32'd0);
        chk("rst_cmp_b",     32'(cmp_b),     32'd0);
        chk("rst_max",       32'(out_max),   32'd0);
        chk("rst_min",       32'(out_min),   32'd0);
        chk("rst_cnt",       32'(out_cnt),   32'd0);

        rst_n = 1'b1;
        tick();
        tick();

        // Frame 5, -3, 127, -128, 0
        pulse_start();
        chk("t1_busy",  32'(busy),     32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        push(0, 8'h05, 1'b0);
        push(0, 8'hFD, 1'b0);
        push(0, 8'h7F, 1'b0);
        // LAST without a transfer must not end the frame
        in_last = 1'b1;
        tick(); tick(); tick();
        chk("t1_last_noxfer_ready", 32'(in_ready),  32'd1);
        chk("t1_last_noxfer_valid", 32'(out_valid), 32'd0);
        in_last = 1'b0;
        push(0, 8'h80, 1'b0);
        push(0, 8'h00, 1'b1);
        chk("t1_lat_c1", 32'(out_valid), 32'd0);
        tick();
        chk("t1_lat_c2", 32'(out_valid), 32'd0);
        tick();
        chk("t1_lat_c3", 32'(out_valid), 32'd1);
        chk("t1_max", 32'(out_max), 32'h7F);
        chk("t1_min", 32'(out_min), 32'h80);
        chk("t1_cnt", 32'(out_cnt), 32'd5);
        release_result();
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        chk("t1_idle_busy",  32'(busy),      32'd0);
        chk("t1_idle_max_kept", 32'(out_max), 32'h7F);

        // Single-sample frame -7
        pulse_start();
        push(0, 8'hF9, 1'b1);
        chk("t2_lat_c1", 32'(out_valid), 32'd1);
        chk("t2_max", 32'(out_max), 32'hF9);
        chk("t2_min", 32'(out_min), 32'hF9);
        chk("t2_cnt", 32'(out_cnt), 32'd1);
        release_result();

        // Frame 4, 4, -1, 4 (ties keep the first occurrence)
        pulse_start();
        push(0, 8'h04, 1'b0);
        push(0, 8'h04, 1'b0);
        push(0, 8'hFF, 1'b0);
        push(0, 8'h04, 1'b1);
        wait_valid(0);
        chk("t3_max", 32'(out_max), 32'h04);
        chk("t3_min", 32'(out_min), 32'hFF);
        chk("t3_cnt", 32'(out_cnt), 32'd4);
`ifdef MINMAX_IDX_EN
        chk("t3_max_idx", 32'(out_max_idx), 32'd0);
        chk("t3_min_idx", 32'(out_min_idx), 32'd2);
`endif

        // Back-pressure in DONE with a START pulse in the middle
        for (int i = 0; i < 10; i++) begin
            start = (i == 5);
            tick();
            chk("t4_valid", 32'(out_valid), 32'd1);
            chk("t4_busy",  32'(busy),      32'd1);
            chk("t4_max",   32'(out_max),   32'h04);
            chk("t4_min",   32'(out_min),   32'hFF);
            chk("t4_cnt",   32'(out_cnt),   32'd4);
        end
        start = 1'b0;
        release_result();
        chk("t4_idle_busy",  32'(busy),      32'd0);
        chk("t4_idle_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t4_start_ignored", 32'(in_ready), 32'd0);

        // Reset in the middle of a 3-sample frame
        pulse_start();
        push(0, 8'h0A, 1'b0);
        push(0, 8'h14, 1'b0);
        chk("t5_cmpmax_a", 32'(cmp_a), 32'h14);
        chk("t5_cmpmax_b", 32'(cmp_b), 32'h0A);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(in_ready),  32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_busy",  32'(busy),      32'd0);
        chk("t5_rst_cmp_a", 32'(cmp_a),     32'd0);
        chk("t5_rst_cmp_b", 32'(cmp_b),     32'd0);
        chk("t5_rst_max",   32'(out_max),   32'd0);
        chk("t5_rst_min",   32'(out_min),   32'd0);
        chk("t5_rst_cnt",   32'(out_cnt),   32'd0);
        tick();
        tick();
        // START coincident with reset release is dropped
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start_at_release", 32'(busy), 32'd0);
        tick();
        pulse_start();
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b1);
        wait_valid(0);
        chk("t5_max", 32'(out_max), 32'h02);
        chk("t5_min", 32'(out_min), 32'h01);
        chk("t5_cnt", 32'(out_cnt), 32'd2);
        release_result();

        // CW=2 instance: frame 0..5, count saturates at 3
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        push(1, 8'h00, 1'b0);
        for (int s = 1; s <= 5; s++) begin
            push(1, 8'(s), (s == 5));
            chk("t6_cmpmax_a", 32'(cmp_a2), 32'(s));
            chk("t6_cmpmax_b", 32'(cmp_b2), 32'(s - 1));
            tick();
            chk("t6_cmpmin_a", 32'(cmp_a2), 32'(s));
            chk("t6_cmpmin_b", 32'(cmp_b2), 32'd0);
        end
        tick();
        chk("t6_valid", 32'(out_valid2), 32'd1);
        chk("t6_cnt",   32'(out_cnt2),   32'd3);
        chk("t6_max",   32'(out_max2),   32'h05);
        chk("t6_min",   32'(out_min2),   32'h00);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        chk("t6_idle_busy", 32'(busy2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
